lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
Load/store unit back-end sitting directly upstream of the mem_if master modport. It accepts one byte/half/word load or store request at a time from the execute stage and drives the mem_if master signals (m_valid/m_addr/m_wdata/m_wstrb). It then returns an aligned, sign- or zero-extended result, or a completion, to writeback. A non-zero m_wstrb denotes a write; m_wstrb=0 denotes a read; s_rdata is valid in the cycle s_ready is high.

Parameters:
TAG_W, 5, width of the destination-register tag carried from request to response.
TIMEOUT_CYCLES, 256, cycles m_valid may stay high without s_ready before abort (used only with LSU_TIMEOUT_EN).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend load (LBU/LHU)
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-aligned
req_tag  in  TAG_W  destination tag
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  writeback accepts response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_tag  out  TAG_W  tag of the completed request
rsp_err  out  1  misaligned/illegal (or timeout)
m_valid  out  1  mem_if master valid
m_addr  out  32  word address {addr[31:2],2'b00}
m_wdata  out  32  replicated store data
m_wstrb  out  4  byte strobes; 0000 for loads
s_ready  in  1  mem_if slave ready
s_rdata  in  32  mem_if read data

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0 except req_ready=1. m_valid drops in the same cycle rst rises; the slave tolerates an abandoned request.
- FSM IDLE/BUS/RESP; req_ready = (state==IDLE).
- IDLE: on req_valid, latch the request.
  - Misaligned cases: half with addr[0]=1, word with addr[1:0]!=0, or size=11. Go to RESP with err=1 and no bus cycle.
  - Otherwise go to BUS with registered m_* driven the next cycle.
- BUS: m_valid=1; m_addr/m_wdata/m_wstrb stable until s_ready. On s_ready, capture s_rdata, drop m_valid next cycle, go to RESP.
- RESP: rsp_valid=1, outputs stable; on rsp_ready go to IDLE. A new request can be accepted the cycle after the handshake (no overlap).
- Latency: accept at T, m_valid at T+1, s_ready at T+k (k≥1), rsp_valid at T+k+1. Misaligned: rsp_valid at T+1.
- Strobes:
  - byte: 0001<<addr[1:0]
  - half: 0011<<{addr[1],0}
  - word: 1111
  - loads: 0000
- Write data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
- Load extract: shift captured rdata right by 8*addr[1:0], then extend. Byte/half use sign extension unless req_unsigned; word is unchanged.
- Stores complete with rsp_rdata=0. rsp_tag always equals the latched req_tag.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined: a counter runs in BUS, cleared on entry. When it reaches TIMEOUT_CYCLES-1 without s_ready, m_valid drops next cycle and the FSM goes to RESP with err=1, rdata=0.
- Undefined: no counter; BUS waits indefinitely; rsp_err reports misalignment/illegal size only.

Decomposition:
Package lsu_pkg holds:
- enum lsu_size_e (BYTE/HALF/WORD/ILLEGAL)
- enum lsu_state_e (IDLE/BUS/RESP)
- function gen_wstrb(size, addr[1:0])
- function misaligned(size, addr[1:0])

One combinational sub-module, lsu_load_align (rdata, offset, size, unsigned -> extended data), instantiated in lsu_mem_master.

Test Plan:
1. SW addr 0x1000 data 0xDEADBEEF, s_ready after 2 cycles -> m_addr 0x1000, m_wstrb 1111, m_wdata 0xDEADBEEF; rsp_valid err=0 rdata=0.
2. SB addr 0x1003 data 0x000000A5 -> m_addr 0x1000, m_wstrb 1000, m_wdata 0xA5A5A5A5.
3. LB addr 0x2001, s_rdata 0x123480FF -> rsp_rdata 0xFFFFFF80; same as LBU -> 0x00000080; m_wstrb 0000.
4. LH addr 0x2002, s_rdata 0x80010000 -> 0xFFFF8001; LW addr 0x2002 -> no m_valid, rsp_err=1 at T+1.
5. rst pulsed while m_valid=1 -> m_valid=0 immediately, rsp_valid never fires, req_ready=1 after release.
6. (LSU_TIMEOUT_EN) s_ready stuck 0 -> m_valid held 256 cycles, then rsp_err=1, rsp_rdata=0; rsp_rdata held stable until rsp_ready.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store unit memory master.
//   lsu_size_e  : access size encoding as carried on req_size
//   lsu_state_e : master FSM states
//   gen_wstrb   : byte-lane strobes for a store of a given size/offset
//   misaligned  : flags accesses that must not reach the bus
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } lsu_state_e;

  function automatic logic [3:0] gen_wstrb(input lsu_size_e size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 4'b0001 << off;
      SIZE_HALF: return 4'b0011 << {off[1], 1'b0};
      SIZE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input lsu_size_e size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      SIZE_WORD: return off != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data aligner: moves the addressed byte/half down to bit 0
// and sign- or zero-extends it. Words pass through unchanged.
//   rdata_i     [31:0] raw word returned by the memory
//   offset_i    [1:0]  byte offset within the word
//   size_i      [1:0]  access size (lsu_size_e encoding)
//   unsigned_i         1 = zero-extend, 0 = sign-extend
//   data_o      [31:0] aligned, extended load result
// -----------------------------------------------------------------------------
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (lsu_size_e'(size_i))
      SIZE_BYTE: data_o = unsigned_i ? {24'h000000, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data_o = unsigned_i ? {16'h0000, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default:   data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
// Load/store unit back-end driving a mem_if master. Accepts one request at a
// time, issues a single bus transfer (or none, for misaligned/illegal
// accesses) and returns an extended load result or store completion.
//
// Optional build macro: LSU_TIMEOUT_EN -- abort a bus transfer with rsp_err
// after TIMEOUT_CYCLES cycles without s_ready. Undefined: wait indefinitely.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_*               request channel from execute (valid/ready handshake)
//   rsp_*               response channel to writeback (valid/ready handshake)
//   m_valid/m_addr/m_wdata/m_wstrb   mem_if master outputs (wstrb=0 is a read)
//   s_ready/s_rdata     mem_if slave handshake and read data
// -----------------------------------------------------------------------------
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned TAG_W          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             m_valid,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  output logic [3:0]       m_wstrb,
  input  logic             s_ready,
  input  logic [31:0]      s_rdata
);

  lsu_state_e       state_q, state_d;
  logic             we_q, we_d;
  lsu_size_e        size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       off_q, off_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      load_data;
  lsu_size_e        req_size_e;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign req_size_e = lsu_size_e'(req_size);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    tag_d   = tag_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d   = req_we;
          size_d = req_size_e;
          uns_d  = req_unsigned;
          off_d  = req_addr[1:0];
          tag_d  = req_tag;
          if (misaligned(req_size_e, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            addr_d  = {req_addr[31:2], 2'b00};
            wstrb_d = req_we ? gen_wstrb(req_size_e, req_addr[1:0]) : 4'b0000;
            case (req_size_e)
              SIZE_BYTE: wdata_d = {4{req_wdata[7:0]}};
              SIZE_HALF: wdata_d = {2{req_wdata[15:0]}};
              default:   wdata_d = req_wdata;
            endcase
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (s_ready) begin
          rdata_d = s_rdata;
          state_d = RESP;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      uns_q   <= 1'b0;
      off_q   <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  lsu_load_align u_load_align (
    .rdata_i    (rdata_q),
    .offset_i   (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  // m_valid decodes straight from state so an async reset kills it at once.
  assign req_ready = (state_q == IDLE);
  assign m_valid   = (state_q == BUS);
  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_tag   = tag_q;
  // Stores, errors and timeouts report zero data.
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? load_data : '0;

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

  localparam int unsigned TAG_W = 5;
  localparam int unsigned TO    = 256;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]       req_size;
  logic [31:0]      req_addr, req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [31:0]      rsp_rdata;
  logic [TAG_W-1:0] rsp_tag;
  logic             m_valid, s_ready;
  logic [31:0]      m_addr, m_wdata, s_rdata;
  logic [3:0]       m_wstrb;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  lsu_mem_master #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_misaligned(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  function automatic logic [3:0] ref_strb(input bit we, input logic [1:0] size, input logic [31:0] addr);
    int unsigned off = addr % 4;
    if (!we) return 4'd0;
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return 4'(3 << off);
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'd0) return (w & 32'hFF) * 32'h01010101;
    if (size == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input bit uns,
                                           input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] sh, v;
    sh = rd >> (8 * (addr % 4));
    if (size == 2'd0) begin
      v = sh & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = sh & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = sh;
    end
    return v;
  endfunction

  // One complete transaction: k = cycles until s_ready, hold = cycles rsp stalled.
  task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [TAG_W-1:0] tag, input int unsigned k,
                        input logic [31:0] rd, input int unsigned hold);
    logic [31:0] exp_rdata;
    logic        exp_err;
    @(negedge clk);
    check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_tag = tag;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_tag = TAG_W'($urandom); req_size = 2'($urandom); req_we = 1'($urandom);
    if (ref_misaligned(size, addr)) begin
      exp_err = 1'b1; exp_rdata = 32'd0;
      check_eq("mis_m_valid", {31'd0, m_valid}, 32'd0);
    end else begin
      exp_err = 1'b0;
      exp_rdata = we ? 32'd0 : ref_load(size, uns, addr, rd);
      check_eq("m_valid", {31'd0, m_valid}, 32'd1);
      check_eq("m_addr", m_addr, addr & 32'hFFFF_FFFC);
      check_eq("m_wstrb", {28'd0, m_wstrb}, {28'd0, ref_strb(we, size, addr)});
      if (we) check_eq("m_wdata", m_wdata, ref_wdata(size, wdata));
      check_eq("bus_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("bus_req_ready", {31'd0, req_ready}, 32'd0);
      for (int i = 1; i < k; i++) begin
        @(negedge clk);
        check_eq("wait_m_valid", {31'd0, m_valid}, 32'd1);
        check_eq("wait_m_addr", m_addr, addr & 32'hFFFF_FFFC);
        check_eq("wait_m_wstrb", {28'd0, m_wstrb}, {28'd0, ref_strb(we, size, addr)});
      end
      s_ready = 1'b1; s_rdata = rd;
      @(negedge clk);
      s_ready = 1'b0; s_rdata = $urandom;
      check_eq("done_m_valid", {31'd0, m_valid}, 32'd0);
    end
    check_eq("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    check_eq("rsp_rdata", rsp_rdata, exp_rdata);
    check_eq("rsp_tag", {27'd0, rsp_tag}, {27'd0, tag});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("hold_rsp_rdata", rsp_rdata, exp_rdata);
      check_eq("hold_rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("after_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int unsigned cnt;
    logic [1:0]  sz;
    logic [31:0] a;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_tag = '0;
    rsp_ready = 1'b0; s_ready = 1'b0; s_rdata = '0;

    @(negedge clk);
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_m_wstrb", {28'd0, m_wstrb}, 32'd0);
    check_eq("rst_m_addr", m_addr, 32'd0);
    rst = 1'b0;

    // Directed cases
    do_req(1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEADBEEF, 5'd1, 2, 32'h0, 1);
    do_req(1'b1, 2'd0, 1'b0, 32'h1003, 32'h000000A5, 5'd2, 1, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h2001, 32'h0, 5'd3, 1, 32'h123480FF, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h2001, 32'h0, 5'd4, 3, 32'h123480FF, 2);
    do_req(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 5'd5, 1, 32'h80010000, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h2002, 32'h0, 5'd6, 1, 32'h0, 1);
    do_req(1'b1, 2'd1, 1'b0, 32'h2003, 32'h1234, 5'd7, 1, 32'h0, 0);
    do_req(1'b0, 2'd3, 1'b1, 32'h2000, 32'h0, 5'd8, 1, 32'h0, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h3002, 32'hCAFEBEEF, 5'd31, 2, 32'h0, 0);

    // Reset while a bus transfer is outstanding
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h4000; req_tag = 5'd9;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("prerst_m_valid", {31'd0, m_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("async_m_valid", {31'd0, m_valid}, 32'd0);
    check_eq("async_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("postrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("postrst_req_ready", {31'd0, req_ready}, 32'd1);
    end

`ifdef LSU_TIMEOUT_EN
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h5000; req_tag = 5'd10;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (m_valid && cnt < TO + 50) begin
      cnt++;
      @(negedge clk);
    end
    check_eq("to_m_valid_cycles", cnt, TO);
    check_eq("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("to_hold_rdata", rsp_rdata, 32'd0);
      check_eq("to_hold_valid", {31'd0, rsp_valid}, 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("to_after_ready", {31'd0, req_ready}, 32'd1);
`endif

    // Randomized transactions
    for (int n = 0; n < 200; n++) begin
      sz = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, TAG_W'($urandom),
             $urandom_range(1, 4), $urandom, $urandom_range(0, 2));
    end

    cnt = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
